// File: rtl/lifo_stack.sv
// Parametrised LIFO data stack: push/pop strobes, registered pop output,
// sticky overflow/underflow, flush and a high-water mark of occupancy.
module lifo_stack #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_en,
    input  logic              pop_en,
    input  logic              flush,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [DATA_W-1:0] top_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  high_water,
    output logic              overflow,
    output logic              underflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_high_water;
    logic [DATA_W-1:0] r_pop_data;
    logic [DATA_W-1:0] r_top_data;
    logic              r_pop_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_is_full;
    logic              w_is_empty;
    logic              w_do_push;
    logic              w_do_pop;
    logic              w_do_swap;
    logic              w_do_pass;
    logic              w_ovf_evt;
    logic              w_unf_evt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_below_idx;

    assign w_is_full  = (r_count == DEPTH_C);
    assign w_is_empty = (r_count == '0);

    // Truncated indices are only used when the matching occupancy guard holds.
    assign w_wr_idx    = IDX_W'(r_count);
    assign w_top_idx   = IDX_W'(r_count - CNT_W'(1));
    assign w_below_idx = IDX_W'(r_count - CNT_W'(2));

    always_comb begin
        w_do_push = push_en && !pop_en && !w_is_full;
        w_do_pop  = pop_en && !push_en && !w_is_empty;
        w_do_swap = push_en && pop_en && !w_is_empty;
        w_do_pass = push_en && pop_en && w_is_empty;
        w_ovf_evt = push_en && !pop_en && w_is_full;
        w_unf_evt = pop_en && !push_en && w_is_empty;
        w_cnt_nxt = r_count;
        if (w_do_push) begin
            w_cnt_nxt = r_count + CNT_W'(1);
        end else if (w_do_pop) begin
            w_cnt_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (w_do_push) begin
                r_mem[w_wr_idx] <= push_data;
            end else if (w_do_swap) begin
                r_mem[w_top_idx] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_high_water <= '0;
            r_pop_data   <= '0;
            r_top_data   <= '0;
            r_pop_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (flush) begin
            r_count      <= '0;
            r_high_water <= '0;
            r_pop_data   <= '0;
            r_top_data   <= '0;
            r_pop_valid  <= 1'b0;
            if (err_clr) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
        end else begin
            r_count     <= w_cnt_nxt;
            r_pop_valid <= w_do_pop || w_do_swap || w_do_pass;
            if (w_do_pop || w_do_swap) begin
                r_pop_data <= r_mem[w_top_idx];
            end else if (w_do_pass) begin
                r_pop_data <= push_data;
            end
            if (w_do_push || w_do_swap) begin
                r_top_data <= push_data;
            end else if (w_do_pop) begin
                r_top_data <= (r_count >= CNT_W'(2)) ? r_mem[w_below_idx] : '0;
            end
            if (w_cnt_nxt > r_high_water) begin
                r_high_water <= w_cnt_nxt;
            end
            // A fresh error event in the same cycle as err_clr keeps the flag set.
            r_overflow  <= (r_overflow && !err_clr) || w_ovf_evt;
            r_underflow <= (r_underflow && !err_clr) || w_unf_evt;
        end
    end

    assign count      = r_count;
    assign full       = w_is_full;
    assign empty      = w_is_empty;
    assign high_water = r_high_water;
    assign pop_data   = r_pop_data;
    assign pop_valid  = r_pop_valid;
    assign top_data   = r_top_data;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack (DEPTH=4): directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_lifo_stack;

    localparam int DW = 12;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          push_en;
    logic          pop_en;
    logic          flush;
    logic          err_clr;
    logic [DW-1:0] push_data;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic [DW-1:0] top_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [CW-1:0] high_water;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    int q[$];
    int m_pd;
    int m_pv;
    int m_hw;
    int m_ovf;
    int m_unf;

    always #5 clk = ~clk;

    lifo_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_en    (push_en),
        .pop_en     (pop_en),
        .flush      (flush),
        .err_clr    (err_clr),
        .push_data  (push_data),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .top_data   (top_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .high_water (high_water),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int top;
        top = (q.size() > 0) ? q[$] : 0;
        check("count", int'(count), q.size());
        check("full", int'(full), int'(q.size() == DP));
        check("empty", int'(empty), int'(q.size() == 0));
        check("top_data", int'(top_data), top);
        check("pop_valid", int'(pop_valid), m_pv);
        check("pop_data", int'(pop_data), m_pd);
        check("high_water", int'(high_water), m_hw);
        check("overflow", int'(overflow), m_ovf);
        check("underflow", int'(underflow), m_unf);
    endtask

    // One clock with the given inputs, then model update and full compare.
    task automatic cyc(input bit p, input bit po, input int d,
                       input bit fl = 0, input bit clr = 0, input bit rst = 0);
        bit ovf_evt;
        bit unf_evt;
        push_en   = p;
        pop_en    = po;
        push_data = DW'(d);
        flush     = fl;
        err_clr   = clr;
        reset     = rst;
        @(posedge clk);
        #1;
        ovf_evt = 0;
        unf_evt = 0;
        if (rst) begin
            q.delete();
            m_pd = 0; m_pv = 0; m_hw = 0; m_ovf = 0; m_unf = 0;
        end else if (fl) begin
            q.delete();
            m_pd = 0; m_pv = 0; m_hw = 0;
            if (clr) begin
                m_ovf = 0; m_unf = 0;
            end
        end else begin
            m_pv = 0;
            if (p && po) begin
                m_pv = 1;
                if (q.size() == 0) begin
                    m_pd = d;
                end else begin
                    m_pd = q.pop_back();
                    q.push_back(d);
                end
            end else if (p) begin
                if (q.size() < DP) q.push_back(d);
                else ovf_evt = 1;
            end else if (po) begin
                if (q.size() > 0) begin
                    m_pd = q.pop_back();
                    m_pv = 1;
                end else begin
                    unf_evt = 1;
                end
            end
            if (clr) begin
                m_ovf = 0; m_unf = 0;
            end
            if (ovf_evt) m_ovf = 1;
            if (unf_evt) m_unf = 1;
            if (q.size() > m_hw) m_hw = q.size();
        end
        check_all();
    endtask

    initial begin
        m_pd = 0; m_pv = 0; m_hw = 0; m_ovf = 0; m_unf = 0;
        reset = 1'b1; push_en = 1'b0; pop_en = 1'b0; flush = 1'b0;
        err_clr = 1'b0; push_data = '0;
        cyc(0, 0, 0, 0, 0, 1);
        check("rst_empty", int'(empty), 1);

        cyc(1, 0, 'h011); cyc(1, 0, 'h022); cyc(1, 0, 'h033); cyc(1, 0, 'h044);
        check("fill_top", int'(top_data), 'h044);
        check("fill_full", int'(full), 1);
        cyc(1, 0, 'h055);
        check("ovf_count", int'(count), 4);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_top", int'(top_data), 'h044);

        cyc(0, 1, 0); check("pop1", int'(pop_data), 'h044);
        cyc(0, 1, 0); check("pop2", int'(pop_data), 'h033);
        cyc(0, 1, 0); check("pop3", int'(pop_data), 'h022);
        cyc(0, 1, 0); check("pop4", int'(pop_data), 'h011);
        check("drain_top", int'(top_data), 0);
        cyc(0, 1, 0);
        check("unf_valid", int'(pop_valid), 0);
        check("unf_flag", int'(underflow), 1);
        check("hw4", int'(high_water), 4);

        cyc(1, 0, 'h0A0); cyc(1, 0, 'h0B0);
        cyc(1, 1, 'h0C0);
        check("swap_pd", int'(pop_data), 'h0B0);
        check("swap_top", int'(top_data), 'h0C0);
        check("swap_cnt", int'(count), 2);
        cyc(0, 1, 0); check("after_swap", int'(pop_data), 'h0C0);
        cyc(0, 1, 0);

        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 'h123);
        check("pass_pd", int'(pop_data), 'h123);
        check("pass_pv", int'(pop_valid), 1);
        check("pass_unf", int'(underflow), 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 'h200 + i);
        cyc(1, 1, 'h2FF);
        check("fullswap_cnt", int'(count), 4);
        check("fullswap_ovf", int'(overflow), 0);

        cyc(1, 0, 'h300);
        cyc(0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0);
        cyc(1, 0, 'h301); cyc(1, 0, 'h302); cyc(1, 0, 'h303);
        cyc(0, 0, 0, 1);
        check("flush_cnt", int'(count), 0);
        check("flush_hw", int'(high_water), 0);
        check("flush_ovf_kept", int'(overflow), 1);
        check("flush_unf_kept", int'(underflow), 1);
        cyc(0, 0, 0, 0, 1);
        check("clr_ovf", int'(overflow), 0);
        check("clr_unf", int'(underflow), 0);
        cyc(0, 1, 0, 0, 1);
        check("clr_vs_evt", int'(underflow), 1);

        cyc(1, 0, 'h401); cyc(1, 0, 'h402);
        cyc(1, 0, 'h403, 0, 0, 1);
        check("rst_cnt", int'(count), 0);
        check("rst_top", int'(top_data), 0);
        check("rst_unf", int'(underflow), 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 4095)),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
